cpu_traffic_gen: RTL and testbench
==================================

CPU_TRAFFIC_GEN -- requirements
Module: cpu_traffic_gen

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 16, CPU address width.
REQ-002 SHALL provide parameter DATA_WIDTH, default 8, CPU data width.
REQ-003 SHALL provide parameter CNT_WIDTH, default 8, transaction-count width.
REQ-004 SHALL provide parameter STRIDE, default 4, address step used in mode 2.
REQ-005 SHALL provide parameter LFSR_SEED, default 16'hACE1, reset value of the 16-bit LFSR.
REQ-006 SHALL provide parameter TIMEOUT, default 64, maximum number of WAIT cycles per transaction.
REQ-007 clk  in  1  single clock; all state updates on rising edge.
REQ-008 rst  in  1  reset, asynchronous and active-high.
REQ-009 start  in  1  level request to run one batch.
REQ-010 mode  in  2  0 sequential, 1 LFSR random, 2 strided, 3 treated as 0.
REQ-011 num_txn  in  CNT_WIDTH  transactions per batch, sampled on start.
REQ-012 trig  in  1  cache ready; completes the outstanding transaction.
REQ-013 din  in  DATA_WIDTH  read data returned by the cache.
REQ-014 Address  out  ADDR_WIDTH  CPU address.
REQ-015 wr_rd  out  1  1 write, 0 read.
REQ-016 cs  out  1  request strobe.
REQ-017 DOut  out  DATA_WIDTH  write data.
REQ-018 busy  out  1  batch in progress.
REQ-019 done  out  1  batch finished.
REQ-020 err  out  1  timeout occurred in the last batch.
REQ-021 txn_count  out  CNT_WIDTH  transactions completed in the current or last batch.
REQ-022 mismatch_cnt  out  CNT_WIDTH  read-check failures.

Function
REQ-023 States SHALL be IDLE, ISSUE, WAIT and DONE.
REQ-024 In IDLE with start=1, the block SHALL latch num_txn and mode, clear txn_count and err, and go to ISSUE; if num_txn=0 it SHALL go directly to DONE.
REQ-025 ISSUE SHALL assert cs for exactly one cycle with Address, wr_rd and DOut valid, then go to WAIT.
REQ-026 In WAIT, cs SHALL be 0 and Address, wr_rd and DOut SHALL hold stable.
REQ-027 trig=1 in WAIT SHALL increment txn_count; if the new count equals num_txn the block SHALL go to DONE, else compute the next request and go to ISSUE.
REQ-028 trig in any state other than WAIT SHALL be ignored.
REQ-029 Mode 0 SHALL issue write then read to the same address, starting at address 0; the address SHALL increment by 1 after each read and wrap modulo 2^ADDR_WIDTH.
REQ-030 Mode 1 SHALL set Address = LFSR[ADDR_WIDTH-1:0] and wr_rd = LFSR[0]. The LFSR SHALL use polynomial x^16+x^14+x^13+x^11+1 and advance once per completed transaction.
REQ-031 Mode 2 SHALL issue reads only; the address SHALL step by STRIDE from 0 and wrap modulo 2^ADDR_WIDTH.
REQ-032 DOut SHALL equal Address[DATA_WIDTH-1:0] XOR 8'h5A, zero-extended or truncated to DATA_WIDTH.
REQ-033 If WAIT lasts TIMEOUT cycles without trig, the block SHALL set err=1 and go to DONE.
REQ-034 In DONE, done SHALL be 1 and busy 0; the block SHALL return to IDLE when start=0.
REQ-035 busy SHALL be 1 exactly in ISSUE and WAIT.
REQ-036 Changes to mode or num_txn during a batch SHALL have no effect.
REQ-037 txn_count SHALL saturate and never wrap.

Reset
REQ-038 rst=1 SHALL immediately force IDLE and set Address=0, wr_rd=0, cs=0, DOut=0, busy=0, done=0, err=0, txn_count=0, mismatch_cnt=0 and LFSR=LFSR_SEED.
REQ-039 Reset mid-batch SHALL abort the batch without issuing further cs pulses.

Configuration
REQ-040 With macro CPU_TRAFFIC_GEN_CHECK_EN defined, each mode-0 read completing on trig SHALL compare din against the DOut of the preceding write, and mismatch_cnt SHALL increment (saturating) on inequality. mismatch_cnt SHALL be cleared at batch start.
REQ-041 Without CPU_TRAFFIC_GEN_CHECK_EN, mismatch_cnt SHALL be tied to 0 and no comparison logic SHALL exist.

Verification
REQ-042 Mode 0, num_txn=4, trig 2 cycles after each cs -> Address 0,0,1,1; wr_rd 1,0,1,0; DOut 8'h5A at address 0; done=1; txn_count=4.
REQ-043 Mode 2, num_txn=3, STRIDE=4 -> reads at 0, 4, 8; exactly 3 cs pulses, each 1 cycle wide.
REQ-044 Mode 1, num_txn=2 after reset -> first Address=16'hACE1 with wr_rd=1; second Address equals the next LFSR value.
REQ-045 Trig never asserted -> err=1 and done=1 exactly TIMEOUT cycles into WAIT; txn_count=0.
REQ-046 rst pulsed during WAIT of transaction 2 -> all outputs zero the same cycle; cs stays 0 afterwards until a new start.
REQ-047 With CPU_TRAFFIC_GEN_CHECK_EN, mode 0, din forced to 8'h00 on reads, num_txn=4 -> mismatch_cnt=2.

Source files
------------

// File: rtl/cpu_traffic_gen.sv
// rtl/cpu_traffic_gen.sv - CPU-side request generator driving a cache with sequential, LFSR or strided traffic.
// Optional read-back checking of mode-0 writes is enabled by defining CPU_TRAFFIC_GEN_CHECK_EN.
module cpu_traffic_gen #(
   parameter int          ADDR_WIDTH = 16,
   parameter int          DATA_WIDTH = 8,
   parameter int          CNT_WIDTH  = 8,
   parameter int          STRIDE     = 4,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter int          TIMEOUT    = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic [CNT_WIDTH-1:0]  num_txn,
   input  logic                  trig,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [ADDR_WIDTH-1:0] Address,
   output logic                  wr_rd,
   output logic                  cs,
   output logic [DATA_WIDTH-1:0] DOut,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [CNT_WIDTH-1:0]  txn_count,
   output logic [CNT_WIDTH-1:0]  mismatch_cnt
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t                state_q;
   logic [1:0]            mode_q;
   logic [CNT_WIDTH-1:0]  num_q;
   logic [CNT_WIDTH-1:0]  txn_count_q;
   logic [CNT_WIDTH-1:0]  cnt_inc_d;
   logic [15:0]           lfsr_q;
   logic [15:0]           lfsr_d;
   logic [TW-1:0]         wait_cnt_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] first_addr_d;
   logic [ADDR_WIDTH-1:0] next_addr_d;
   logic                  wr_q;
   logic                  first_wr_d;
   logic                  next_wr_d;
   logic [DATA_WIDTH-1:0] dout_q;
   logic                  cs_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  err_q;

   function automatic logic [DATA_WIDTH-1:0] dout_of(input logic [ADDR_WIDTH-1:0] a);
      return DATA_WIDTH'(a) ^ DATA_WIDTH'(8'h5A);
   endfunction

   // Next request is derived from the one just completed, so mode 0 needs no extra phase register.
   always_comb begin
      lfsr_d       = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      cnt_inc_d    = (&txn_count_q) ? txn_count_q : txn_count_q + CNT_WIDTH'(1);
      first_addr_d = '0;
      first_wr_d   = 1'b1;
      next_addr_d  = wr_q ? addr_q : addr_q + ADDR_WIDTH'(1);
      next_wr_d    = ~wr_q;
      case (mode)
         2'd1: begin
            first_addr_d = ADDR_WIDTH'(lfsr_q);
            first_wr_d   = lfsr_q[0];
         end
         2'd2:    first_wr_d = 1'b0;
         default: ;
      endcase
      case (mode_q)
         2'd1: begin
            next_addr_d = ADDR_WIDTH'(lfsr_d);
            next_wr_d   = lfsr_d[0];
         end
         2'd2: begin
            next_addr_d = addr_q + ADDR_WIDTH'(STRIDE);
            next_wr_d   = 1'b0;
         end
         default: ;
      endcase
   end

`ifdef CPU_TRAFFIC_GEN_CHECK_EN
   logic [CNT_WIDTH-1:0] mismatch_q;
   assign mismatch_cnt = mismatch_q;
`else
   logic din_unused;
   assign din_unused   = ^din;
   assign mismatch_cnt = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mode_q      <= 2'd0;
         num_q       <= '0;
         txn_count_q <= '0;
         lfsr_q      <= LFSR_SEED;
         wait_cnt_q  <= '0;
         addr_q      <= '0;
         wr_q        <= 1'b0;
         dout_q      <= '0;
         cs_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef CPU_TRAFFIC_GEN_CHECK_EN
         mismatch_q  <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: if (start) begin
               mode_q      <= mode;
               num_q       <= num_txn;
               txn_count_q <= '0;
               err_q       <= 1'b0;
`ifdef CPU_TRAFFIC_GEN_CHECK_EN
               mismatch_q  <= '0;
`endif
               if (num_txn == '0) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= ISSUE;
                  cs_q    <= 1'b1;
                  busy_q  <= 1'b1;
                  addr_q  <= first_addr_d;
                  wr_q    <= first_wr_d;
                  dout_q  <= dout_of(first_addr_d);
               end
            end
            ISSUE: begin
               cs_q       <= 1'b0;
               wait_cnt_q <= '0;
               state_q    <= WAIT;
            end
            WAIT: if (trig) begin
               txn_count_q <= cnt_inc_d;
               if (mode_q == 2'd1) lfsr_q <= lfsr_d;
`ifdef CPU_TRAFFIC_GEN_CHECK_EN
               if (mode_q != 2'd1 && mode_q != 2'd2 && !wr_q && din != dout_q && !(&mismatch_q))
                  mismatch_q <= mismatch_q + CNT_WIDTH'(1);
`endif
               if (cnt_inc_d == num_q) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= ISSUE;
                  cs_q    <= 1'b1;
                  addr_q  <= next_addr_d;
                  wr_q    <= next_wr_d;
                  dout_q  <= dout_of(next_addr_d);
               end
            end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
               state_q <= DONE;
               err_q   <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end else begin
               wait_cnt_q <= wait_cnt_q + TW'(1);
            end
            DONE: if (!start) begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign Address   = addr_q;
   assign wr_rd     = wr_q;
   assign cs        = cs_q;
   assign DOut      = dout_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign txn_count = txn_count_q;

endmodule

// File: tb/tb_cpu_traffic_gen.sv
// tb/tb_cpu_traffic_gen.sv - randomized self-checking bench for cpu_traffic_gen against a request-list model.
module tb_cpu_traffic_gen;
   localparam int AW      = 16;
   localparam int DW      = 8;
   localparam int CW      = 8;
   localparam int STRIDE  = 4;
   localparam int TIMEOUT = 64;
   localparam logic [15:0] SEED = 16'hACE1;

   logic          clk = 1'b0;
   logic          rst, start, trig;
   logic [1:0]    mode;
   logic [CW-1:0] num_txn;
   logic [DW-1:0] din;
   logic [AW-1:0] Address;
   logic          wr_rd, cs, busy, done, err;
   logic [DW-1:0] DOut;
   logic [CW-1:0] txn_count, mismatch_cnt;

   int vec_cnt  = 0;
   int miss_cnt = 0;
   logic [15:0] lfsr_m;

   always #5 clk = ~clk;

   cpu_traffic_gen #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .STRIDE(STRIDE),
      .LFSR_SEED(SEED), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .num_txn(num_txn),
      .trig(trig), .din(din), .Address(Address), .wr_rd(wr_rd), .cs(cs),
      .DOut(DOut), .busy(busy), .done(done), .err(err),
      .txn_count(txn_count), .mismatch_cnt(mismatch_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Fibonacci LFSR built from the polynomial exponents 16,14,13,11.
   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      int   taps [4] = '{16, 14, 13, 11};
      logic fb = 1'b0;
      foreach (taps[k]) fb ^= l[16 - taps[k]];
      return {fb, l[15:1]};
   endfunction

   function automatic logic [DW-1:0] dout_m(input logic [AW-1:0] a);
      logic [7:0] k = 8'h5A;
      return a[DW-1:0] ^ k;
   endfunction

   // din_sel: 0 returns written data, 1 returns zero, 2 random mix.
   task automatic run_batch(input int md, input int n, input bit rnd, input int din_sel);
      logic [AW-1:0] ea;
      logic          ew;
      int            pulses = 0;
      int            exp_mm = 0;
      int            d;
      mode = 2'(md); num_txn = CW'(n); start = 1'b1;
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         case (md)
            1:       begin ea = lfsr_m;         ew = lfsr_m[0]; end
            2:       begin ea = AW'(i * STRIDE); ew = 1'b0;     end
            default: begin ea = AW'(i / 2);      ew = (i % 2 == 0); end
         endcase
         check("cs_issue", cs, 1'b1);
         check("req", {busy, wr_rd, Address, DOut}, {1'b1, ew, ea, dout_m(ea)});
         if (cs) pulses++;
         if (rnd) begin
            mode    = 2'($urandom);
            num_txn = CW'($urandom);
            trig    = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         trig = 1'b0;
         check("cs_width", cs, 1'b0);
         d = rnd ? $urandom_range(0, 4) : 1;
         repeat (d) begin
            @(negedge clk);
            check("wait_hold", {cs, wr_rd, Address, DOut}, {1'b0, ew, ea, dout_m(ea)});
         end
         case (din_sel)
            0:       din = dout_m(ea);
            1:       din = '0;
            default: din = ($urandom_range(0, 2) == 0) ? DW'($urandom) : dout_m(ea);
         endcase
`ifdef CPU_TRAFFIC_GEN_CHECK_EN
         if ((md == 0 || md == 3) && !ew && din != dout_m(ea)) exp_mm++;
`endif
         trig = 1'b1;
         @(negedge clk);
         trig = 1'b0;
         if (md == 1) lfsr_m = lfsr_step(lfsr_m);
         check("txn_count", txn_count, CW'(i + 1));
      end
      check("end_flags", {done, busy, err, cs}, 4'b1000);
      check("end_count", txn_count, CW'(n));
      check("cs_pulses", pulses, n);
      check("mismatch_cnt", mismatch_cnt, CW'(exp_mm));
      start = 1'b0;
      @(negedge clk);
      check("back_idle", {done, busy}, 2'b00);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; trig = 1'b0; mode = '0; num_txn = '0; din = '0;
      lfsr_m = SEED;
      repeat (2) @(negedge clk);
      check("rst_outs", {Address, wr_rd, cs, DOut, busy, done, err}, '0);
      check("rst_cnts", {txn_count, mismatch_cnt}, '0);
      rst = 1'b0;
      trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
      check("idle_trig", {txn_count, busy, cs}, '0);

      run_batch(0, 4, 1'b0, 0);
      run_batch(2, 3, 1'b0, 0);
      run_batch(1, 2, 1'b0, 0);
      run_batch(0, 4, 1'b0, 1);

      // No trig at all: the batch must end on the timeout with err set.
      mode = 2'd0; num_txn = 8'd3; start = 1'b1;
      @(negedge clk);
      check("to_cs", cs, 1'b1);
      repeat (TIMEOUT) @(negedge clk);
      check("to_before", {done, busy}, 2'b01);
      @(negedge clk);
      check("to_flags", {done, err, busy}, 3'b110);
      check("to_count", txn_count, '0);
      start = 1'b0;
      @(negedge clk);

      // Reset while the second transaction is waiting.
      mode = 2'd0; num_txn = 8'd4; start = 1'b1;
      @(negedge clk);
      @(negedge clk);
      trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
      check("mid_cs2", cs, 1'b1);
      @(negedge clk);
      #2 rst = 1'b1; start = 1'b0;
      #1 check("mid_rst_outs", {Address, wr_rd, cs, DOut, busy, done, err}, '0);
      check("mid_rst_cnts", {txn_count, mismatch_cnt}, '0);
      @(negedge clk);
      rst = 1'b0;
      lfsr_m = SEED;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check("post_rst_quiet", {cs, busy}, 2'b00);
      end
      run_batch(1, 2, 1'b0, 0);

      for (int b = 0; b < 30; b++)
         run_batch($urandom_range(0, 3), $urandom_range(0, 6), 1'b1, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end
endmodule
